booth_divider_seq: RTL and testbench

Sequential signed integer divider. It is the inverse counterpart of the team's combinational radix-4 Booth multiplier and sits beside it in the arithmetic unit. It takes two signed WIDTH-bit operands on a start strobe and computes a truncating (round-toward-zero) quotient and remainder using an iterative non-restoring algorithm. Results come back with a single-cycle done pulse and are held stable until the next accepted start.

---
 rtl/booth_div_pkg.sv | 16 +
 rtl/booth_div_step.sv | 26 ++
 rtl/booth_divider_seq.sv | 134 +++++++++++++
 tb/tb_booth_divider_seq.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/booth_div_pkg.sv
// Shared types and helpers for the sequential signed divider.
package booth_div_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2,
      DONE = 2'd3
   } state_e;

   // Iteration counter must hold the value WIDTH itself.
   function automatic int unsigned cnt_width(input int unsigned w);
      return $clog2(w + 1);
   endfunction

endpackage

// File: rtl/booth_div_step.sv
// One non-restoring division iteration: shift {P,Q}, add/subtract D, emit quotient bit.
module booth_div_step #(
   parameter int unsigned WIDTH = 8
) (
   input  logic [WIDTH:0]   p_i,
   input  logic [WIDTH-1:0] q_i,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH:0]   p_o,
   output logic [WIDTH-1:0] q_o
);

   logic [WIDTH:0] p_sh;
   logic [WIDTH:0] d_ext;

   always_comb begin
      p_sh  = {p_i[WIDTH-1:0], q_i[WIDTH-1]};
      d_ext = {1'b0, d_i};
      p_o   = p_sh - d_ext;
      // Negative partial remainder: restore by adding instead of subtracting
      if (p_i[WIDTH]) begin
         p_o = p_sh + d_ext;
      end
      q_o = {q_i[WIDTH-2:0], ~p_o[WIDTH]};
   end

endmodule

// File: rtl/booth_divider_seq.sv
// Sequential signed truncating divider (non-restoring, one bit per cycle).
// Optional zero-divisor short cut and flag enabled by DIV_ZERO_DETECT_EN.
module booth_divider_seq
   import booth_div_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             busy,
   output logic             done,
   output logic             div_by_zero
);

   localparam int unsigned CW = cnt_width(WIDTH);

   state_e           state_q;
   logic [WIDTH:0]   p_q;
   logic [WIDTH-1:0] q_q;
   logic [WIDTH-1:0] d_q;
   logic [CW-1:0]    cnt_q;
   logic             qneg_q;
   logic             rneg_q;
   logic             dz_q;
   logic [WIDTH-1:0] quot_q;
   logic [WIDTH-1:0] rem_q;
   logic             busy_q;
   logic             done_q;
   logic             dzf_q;

   logic [WIDTH:0]   p_step_c;
   logic [WIDTH-1:0] q_step_c;
   logic [WIDTH-1:0] a_abs_c;
   logic [WIDTH-1:0] b_abs_c;
   logic [WIDTH-1:0] r_mag_c;
   logic [WIDTH-1:0] q_res_c;
   logic [WIDTH-1:0] r_res_c;
   logic             zero_div_c;
   logic             accept_c;

`ifdef DIV_ZERO_DETECT_EN
   assign zero_div_c = (divisor == '0);
`else
   assign zero_div_c = 1'b0;
`endif

   booth_div_step #(.WIDTH(WIDTH)) u_step (
      .p_i (p_q),
      .q_i (q_q),
      .d_i (d_q),
      .p_o (p_step_c),
      .q_o (q_step_c)
   );

   // Operand magnitudes and final sign/correction of the result.
   always_comb begin
      a_abs_c  = dividend[WIDTH-1] ? -dividend : dividend;
      b_abs_c  = divisor[WIDTH-1]  ? -divisor  : divisor;
      accept_c = start && ((state_q == IDLE) || (state_q == DONE));
      r_mag_c  = p_q[WIDTH] ? (p_q[WIDTH-1:0] + d_q) : p_q[WIDTH-1:0];
      q_res_c  = qneg_q ? -q_q : q_q;
      r_res_c  = rneg_q ? -r_mag_c : r_mag_c;
      // Zero divisor never iterated, so Q still holds |dividend|
      if (dz_q) begin
         q_res_c = '1;
         r_res_c = rneg_q ? -q_q : q_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         p_q     <= '0;
         q_q     <= '0;
         d_q     <= '0;
         cnt_q   <= '0;
         qneg_q  <= 1'b0;
         rneg_q  <= 1'b0;
         dz_q    <= 1'b0;
         quot_q  <= '0;
         rem_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         dzf_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE, DONE: begin
               state_q <= IDLE;
               if (accept_c) begin
                  p_q     <= '0;
                  q_q     <= a_abs_c;
                  d_q     <= b_abs_c;
                  cnt_q   <= CW'(WIDTH);
                  qneg_q  <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
                  rneg_q  <= dividend[WIDTH-1];
                  dz_q    <= zero_div_c;
                  busy_q  <= 1'b1;
                  state_q <= zero_div_c ? FIX : CALC;
               end
            end
            CALC: begin
               p_q   <= p_step_c;
               q_q   <= q_step_c;
               cnt_q <= cnt_q - CW'(1);
               if (cnt_q == CW'(1)) begin
                  state_q <= FIX;
               end
            end
            FIX: begin
               quot_q  <= q_res_c;
               rem_q   <= r_res_c;
               dzf_q   <= dz_q;
               busy_q  <= 1'b0;
               done_q  <= 1'b1;
               state_q <= DONE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign quotient    = quot_q;
   assign remainder   = rem_q;
   assign busy        = busy_q;
   assign done        = done_q;
   assign div_by_zero = dzf_q;

endmodule

// File: tb/tb_booth_divider_seq.sv
// Directed bench for booth_divider_seq (WIDTH=8); zero-divisor vectors follow DIV_ZERO_DETECT_EN.
module tb_booth_divider_seq;

   logic       clk;
   logic       rst;
   logic       start;
   logic [7:0] dividend;
   logic [7:0] divisor;
   logic [7:0] quotient;
   logic [7:0] remainder;
   logic       busy;
   logic       done;
   logic       div_by_zero;

   int n_checks = 0;
   int n_errors = 0;

   booth_divider_seq #(.WIDTH(8)) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .dividend    (dividend),
      .divisor     (divisor),
      .quotient    (quotient),
      .remainder   (remainder),
      .busy        (busy),
      .done        (done),
      .div_by_zero (div_by_zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Runs one divide. If start is already high (issued in a DONE cycle) the
   // operands are assumed loaded. pk: cycle at which start is raised with pa/pb.
   task automatic do_div(input string tag, input logic [7:0] a, input logic [7:0] b,
                         input int exp_cyc, input bit chk_val,
                         input logic [7:0] eq, input logic [7:0] er, input logic exp_dz,
                         input int pk, input logic [7:0] pa, input logic [7:0] pb);
      int k;
      int bc;
      k  = 0;
      bc = 0;
      if (!start) begin
         @(negedge clk);
         start    = 1'b1;
         dividend = a;
         divisor  = b;
      end
      @(posedge clk);
      #1;
      start = 1'b0;
      while (k < 40) begin
         k++;
         if (busy) bc++;
         if (k == pk) begin
            start    = 1'b1;
            dividend = pa;
            divisor  = pb;
         end else begin
            start = 1'b0;
         end
         if (done) break;
         @(posedge clk);
         #1;
      end
      check({tag, "_latency"}, k, exp_cyc);
      check({tag, "_busy_cycles"}, bc, exp_cyc - 1);
      check({tag, "_busy_at_done"}, busy, 0);
      check({tag, "_dz"}, div_by_zero, exp_dz);
      if (chk_val) begin
         check({tag, "_quot"}, quotient, eq);
         check({tag, "_rem"}, remainder, er);
      end
   endtask

   initial begin
      int k;
      int seen;
      rst      = 1'b1;
      start    = 1'b0;
      dividend = '0;
      divisor  = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_quot", quotient, 0);
      check("rst_rem", remainder, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_dz", div_by_zero, 0);
      rst = 1'b0;

      do_div("p100_p7", 8'h64, 8'h07, 10, 1, 8'h0E, 8'h02, 1'b0, 0, 8'h00, 8'h00);
      do_div("m100_p7", 8'h9C, 8'h07, 10, 1, 8'hF2, 8'hFE, 1'b0, 0, 8'h00, 8'h00);
      do_div("p100_m7", 8'h64, 8'hF9, 10, 1, 8'hF2, 8'h02, 1'b0, 0, 8'h00, 8'h00);
      do_div("m100_m7", 8'h9C, 8'hF9, 10, 1, 8'h0E, 8'hFE, 1'b0, 0, 8'h00, 8'h00);
      do_div("m128_m1", 8'h80, 8'hFF, 10, 1, 8'h80, 8'h00, 1'b0, 0, 8'h00, 8'h00);
      do_div("m128_p1", 8'h80, 8'h01, 10, 1, 8'h80, 8'h00, 1'b0, 0, 8'h00, 8'h00);
      do_div("p127_p127", 8'h7F, 8'h7F, 10, 1, 8'h01, 8'h00, 1'b0, 0, 8'h00, 8'h00);

`ifdef DIV_ZERO_DETECT_EN
      do_div("p5_zero", 8'h05, 8'h00, 2, 1, 8'hFF, 8'h05, 1'b1, 0, 8'h00, 8'h00);
`else
      do_div("p5_zero", 8'h05, 8'h00, 10, 0, 8'h00, 8'h00, 1'b0, 0, 8'h00, 8'h00);
`endif
      do_div("p9_p3", 8'h09, 8'h03, 10, 1, 8'h03, 8'h00, 1'b0, 0, 8'h00, 8'h00);

      // Start pulse while busy must be ignored.
      do_div("ignore_busy", 8'h64, 8'h07, 10, 1, 8'h0E, 8'h02, 1'b0, 3, 8'h32, 8'h05);
      // Start in the DONE cycle: back-to-back second divide.
      do_div("b2b_first", 8'h64, 8'h07, 10, 1, 8'h0E, 8'h02, 1'b0, 10, 8'h32, 8'h05);
      do_div("b2b_second", 8'h32, 8'h05, 10, 1, 8'h0A, 8'h00, 1'b0, 0, 8'h00, 8'h00);

      // Reset mid-calculation abandons the operation.
      @(negedge clk);
      start    = 1'b1;
      dividend = 8'h64;
      divisor  = 8'h07;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      check("midrst_quot", quotient, 0);
      check("midrst_rem", remainder, 0);
      check("midrst_busy", busy, 0);
      check("midrst_done", done, 0);
      rst  = 1'b0;
      seen = 0;
      for (k = 0; k < 15; k++) begin
         @(posedge clk);
         #1;
         if (done || busy) seen++;
      end
      check("midrst_no_done", seen, 0);
      do_div("after_rst", 8'h14, 8'h03, 10, 1, 8'h06, 8'h02, 1'b0, 0, 8'h00, 8'h00);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
